shift_dispatch_unit: RTL and testbench

- Issue-side counterpart of the combinational shift/bit-manipulation datapath: takes RV32 shift/Zbs/Zbb-rotate micro-ops from the integer scheduler and encodes funct3/funct7/imm into the datapath's 5-bit op code.
- Drives operands into the datapath and returns results to the writeback/ROB with valid/ready handshakes.
- Two-stage pipeline: decode/encode register, then result register. Throughput is one op per cycle; supports flush.

---
 rtl/shift_dispatch_if.sv | 36 +++
 rtl/shift_dispatch_unit.sv | 143 ++++++++++++++
 tb/tb_shift_dispatch_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_dispatch_if.sv
// Issue-side and writeback-side handshake bundle for the shift dispatch unit.
// Signal names keep their direction suffix as seen from the unit itself.
interface shift_dispatch_if #(
  parameter int ROB_W = 5,
  parameter int PRF_W = 6
);
  logic             flush_i;
  logic             issue_valid_i;
  logic             issue_ready_o;
  logic [2:0]       issue_funct3_i;
  logic [6:0]       issue_funct7_i;
  logic             issue_is_imm_i;
  logic [31:0]      issue_rs1_i;
  logic [31:0]      issue_rs2_i;
  logic [4:0]       issue_shamt_i;
  logic [ROB_W-1:0] issue_rob_i;
  logic [PRF_W-1:0] issue_prd_i;
  logic             wb_valid_o;
  logic             wb_ready_i;
  logic [31:0]      wb_data_o;
  logic [ROB_W-1:0] wb_rob_o;
  logic [PRF_W-1:0] wb_prd_o;
  logic             wb_illegal_o;

  modport slave (
    input  flush_i, issue_valid_i, issue_funct3_i, issue_funct7_i, issue_is_imm_i,
           issue_rs1_i, issue_rs2_i, issue_shamt_i, issue_rob_i, issue_prd_i, wb_ready_i,
    output issue_ready_o, wb_valid_o, wb_data_o, wb_rob_o, wb_prd_o, wb_illegal_o
  );

  modport master (
    output flush_i, issue_valid_i, issue_funct3_i, issue_funct7_i, issue_is_imm_i,
           issue_rs1_i, issue_rs2_i, issue_shamt_i, issue_rob_i, issue_prd_i, wb_ready_i,
    input  issue_ready_o, wb_valid_o, wb_data_o, wb_rob_o, wb_prd_o, wb_illegal_o
  );
endinterface

// File: rtl/shift_dispatch_unit.sv
// Two-stage issue/writeback wrapper around the RV32 shift/Zbs/rotate datapath:
// S1 holds the encoded op and operands, S2 holds the registered result.
module shift_dispatch_unit #(
  parameter int ROB_W = 5,
  parameter int PRF_W = 6
) (
  input logic           cpu_clock_i,
  input logic           cpu_reset_n_i,
  shift_dispatch_if.slave bus
);
  localparam logic [4:0] OP_SLL  = 5'b00000;
  localparam logic [4:0] OP_SRL  = 5'b00001;
  localparam logic [4:0] OP_ROL  = 5'b00010;
  localparam logic [4:0] OP_ROR  = 5'b00011;
  localparam logic [4:0] OP_SRA  = 5'b00101;
  localparam logic [4:0] OP_BCLR = 5'b01000;
  localparam logic [4:0] OP_BEXT = 5'b01011;
  localparam logic [4:0] OP_BINV = 5'b11000;
  localparam logic [4:0] OP_BSET = 5'b11010;

  logic             s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic             s2_free, s1_adv, issue_ready, accept;
  logic [4:0]       enc_op;
  logic             enc_ill;
  logic [4:0]       b_lo;
  logic [4:0]       s1_op_q, s1_sh_q;
  logic [31:0]      s1_a_q;
  logic             s1_ill_q;
  logic [ROB_W-1:0] s1_rob_q;
  logic [PRF_W-1:0] s1_prd_q;
  logic [31:0]      res;
  logic [31:0]      onehot;
  logic [5:0]       sh_inv;
  logic [31:0]      wb_data_q;
  logic [ROB_W-1:0] wb_rob_q;
  logic [PRF_W-1:0] wb_prd_q;
  logic             wb_ill_q;

  assign s2_free     = !s2_vld_q | bus.wb_ready_i;
  assign s1_adv      = s1_vld_q & s2_free;
  assign issue_ready = !s1_vld_q | s1_adv;
  assign accept      = bus.issue_valid_i & issue_ready & !bus.flush_i;

  always_comb begin
    enc_op  = OP_SLL;
    enc_ill = 1'b0;
    case ({bus.issue_funct3_i, bus.issue_funct7_i})
      10'b001_0000000: enc_op = OP_SLL;
      10'b101_0000000: enc_op = OP_SRL;
      10'b001_0110000: begin
        enc_op  = OP_ROL;
        enc_ill = bus.issue_is_imm_i;  // Zbb has rori but no roli
      end
      10'b101_0110000: enc_op = OP_ROR;
      10'b101_0100000: enc_op = OP_SRA;
      10'b001_0100100: enc_op = OP_BCLR;
      10'b101_0100100: enc_op = OP_BEXT;
      10'b001_0110100: enc_op = OP_BINV;
      10'b001_0010100: enc_op = OP_BSET;
      default:         enc_ill = 1'b1;
    endcase
  end

  // Only b[4:0] reaches the datapath, so only those bits are staged.
  assign b_lo = bus.issue_is_imm_i ? bus.issue_shamt_i : bus.issue_rs2_i[4:0];

  always_comb begin
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;
    if (bus.flush_i) begin
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end else begin
      if (accept)              s1_vld_d = 1'b1;
      else if (s1_adv)         s1_vld_d = 1'b0;
      if (s1_adv)              s2_vld_d = 1'b1;
      else if (bus.wb_ready_i) s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
    if (!cpu_reset_n_i) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (accept) begin
      s1_op_q  <= enc_op;
      s1_a_q   <= bus.issue_rs1_i;
      s1_sh_q  <= b_lo;
      s1_ill_q <= enc_ill;
      s1_rob_q <= bus.issue_rob_i;
      s1_prd_q <= bus.issue_prd_i;
    end
  end

  // Rotates use the complementary shift; sh=0 gives sh_inv=32, which shifts out to 0.
  assign onehot = 32'b1 << s1_sh_q;
  assign sh_inv = 6'd32 - {1'b0, s1_sh_q};

  always_comb begin
    res = '0;
    case (s1_op_q)
      OP_SLL:  res = s1_a_q << s1_sh_q;
      OP_SRL:  res = s1_a_q >> s1_sh_q;
      OP_ROL:  res = (s1_a_q << s1_sh_q) | (s1_a_q >> sh_inv);
      OP_ROR:  res = (s1_a_q >> s1_sh_q) | (s1_a_q << sh_inv);
      OP_SRA:  res = $unsigned($signed(s1_a_q) >>> s1_sh_q);
      OP_BCLR: res = s1_a_q & ~onehot;
      OP_BEXT: res = {31'b0, s1_a_q[s1_sh_q]};
      OP_BINV: res = s1_a_q ^ onehot;
      OP_BSET: res = s1_a_q | onehot;
      default: res = '0;
    endcase
    if (s1_ill_q) res = '0;
  end

  always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
    if (!cpu_reset_n_i) begin
      wb_data_q <= '0;
      wb_rob_q  <= '0;
      wb_prd_q  <= '0;
      wb_ill_q  <= 1'b0;
    end else if (s1_adv && !bus.flush_i) begin
      wb_data_q <= res;
      wb_rob_q  <= s1_rob_q;
      wb_prd_q  <= s1_prd_q;
      wb_ill_q  <= s1_ill_q;
    end
  end

  assign bus.issue_ready_o = issue_ready;
  assign bus.wb_valid_o    = s2_vld_q;
  assign bus.wb_data_o     = wb_data_q;
  assign bus.wb_rob_o      = wb_rob_q;
  assign bus.wb_prd_o      = wb_prd_q;
  assign bus.wb_illegal_o  = wb_ill_q;
endmodule

// File: tb/tb_shift_dispatch_unit.sv
// Bench for shift_dispatch_unit: queue-based reference model checked every cycle,
// plus directed vectors with literal expected results.
module tb_shift_dispatch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;

  shift_dispatch_if #(.ROB_W(5), .PRF_W(6)) bus();

  shift_dispatch_unit #(.ROB_W(5), .PRF_W(6)) dut (
    .cpu_clock_i  (clk),
    .cpu_reset_n_i(rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rob;
    logic [5:0]  prd;
    logic        ill;
    bit          in_s2;
  } ent_t;
  ent_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference semantics written from the instruction definitions, bit by bit.
  function automatic logic [32:0] ref_op(input logic [2:0] f3, input logic [6:0] f7,
                                         input logic imm, input logic [31:0] a,
                                         input logic [31:0] rs2, input logic [4:0] sh);
    int s;
    logic [31:0] r;
    logic ill;
    s = imm ? int'(sh) : int'(rs2[4:0]);
    r = a;
    ill = 1'b0;
    if (f3 == 3'd1 && f7 == 7'h00)               r = a << s;
    else if (f3 == 3'd5 && f7 == 7'h00)          r = a >> s;
    else if (f3 == 3'd5 && f7 == 7'h20)          r = 32'($signed(a) >>> s);
    else if (f3 == 3'd1 && f7 == 7'h30 && !imm)  repeat (s) r = {r[30:0], r[31]};
    else if (f3 == 3'd5 && f7 == 7'h30)          repeat (s) r = {r[0], r[31:1]};
    else if (f3 == 3'd1 && f7 == 7'h24)          r[s] = 1'b0;
    else if (f3 == 3'd5 && f7 == 7'h24)          r = (a >> s) & 32'd1;
    else if (f3 == 3'd1 && f7 == 7'h34)          r[s] = ~r[s];
    else if (f3 == 3'd1 && f7 == 7'h14)          r[s] = 1'b1;
    else begin ill = 1'b1; r = '0; end
    return {ill, r};
  endfunction

  // Model: at most two ops in flight; the head is visible once it has reached the result stage.
  logic m_ready, m_wbv, m_acc, m_pop;
  logic [32:0] m_res;
  ent_t m_e;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_ready = !(q.size() == 2 && !bus.wb_ready_i);
      m_wbv   = q.size() > 0 && q[0].in_s2;
      m_acc   = bus.issue_valid_i && m_ready && !bus.flush_i;
      m_pop   = m_wbv && bus.wb_ready_i;
      if (m_pop) pop_cnt++;
      if (bus.flush_i) begin
        q.delete();
      end else begin
        if (m_pop) void'(q.pop_front());
        if (q.size() > 0 && !q[0].in_s2) q[0].in_s2 = 1'b1;
        if (m_acc) begin
          m_res = ref_op(bus.issue_funct3_i, bus.issue_funct7_i, bus.issue_is_imm_i,
                         bus.issue_rs1_i, bus.issue_rs2_i, bus.issue_shamt_i);
          m_e.data  = m_res[31:0];
          m_e.ill   = m_res[32];
          m_e.rob   = bus.issue_rob_i;
          m_e.prd   = bus.issue_prd_i;
          m_e.in_s2 = 1'b0;
          q.push_back(m_e);
          acc_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("issue_ready", 32'(bus.issue_ready_o), 32'(!(q.size() == 2 && !bus.wb_ready_i)));
      chk("wb_valid", 32'(bus.wb_valid_o), 32'(q.size() > 0 && q[0].in_s2));
      if (q.size() > 0 && q[0].in_s2) begin
        chk("wb_data", bus.wb_data_o, q[0].data);
        chk("wb_rob", 32'(bus.wb_rob_o), 32'(q[0].rob));
        chk("wb_prd", 32'(bus.wb_prd_o), 32'(q[0].prd));
        chk("wb_illegal", 32'(bus.wb_illegal_o), 32'(q[0].ill));
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] sh,
                       input logic [4:0] rob, input logic [5:0] prd);
    bus.issue_valid_i  = 1'b1;
    bus.issue_funct3_i = f3;
    bus.issue_funct7_i = f7;
    bus.issue_is_imm_i = imm;
    bus.issue_rs1_i    = rs1;
    bus.issue_rs2_i    = rs2;
    bus.issue_shamt_i  = sh;
    bus.issue_rob_i    = rob;
    bus.issue_prd_i    = prd;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, " ready"}, 32'(bus.issue_ready_o), 32'd1);
    chk({nm, " valid"}, 32'(bus.wb_valid_o), 32'd0);
    chk({nm, " data"}, bus.wb_data_o, 32'd0);
    chk({nm, " rob"}, 32'(bus.wb_rob_o), 32'd0);
    chk({nm, " prd"}, 32'(bus.wb_prd_o), 32'd0);
    chk({nm, " illegal"}, 32'(bus.wb_illegal_o), 32'd0);
  endtask

  // One op with writeback ready: result must be visible right after the second edge.
  task automatic one(input string nm, input logic [2:0] f3, input logic [6:0] f7,
                     input logic imm, input logic [31:0] rs1, input logic [31:0] rs2,
                     input logic [4:0] sh, input logic [4:0] rob,
                     input logic [31:0] exp_d, input logic exp_ill);
    bus.wb_ready_i = 1'b1;
    drive(f3, f7, imm, rs1, rs2, sh, rob, 6'(rob + 5'd7));
    cyc;
    bus.issue_valid_i = 1'b0;
    cyc;
    #1;
    chk({nm, " valid"}, 32'(bus.wb_valid_o), 32'd1);
    chk({nm, " data"}, bus.wb_data_o, exp_d);
    chk({nm, " illegal"}, 32'(bus.wb_illegal_o), 32'(exp_ill));
    chk({nm, " rob"}, 32'(bus.wb_rob_o), 32'(rob));
    chk({nm, " prd"}, 32'(bus.wb_prd_o), 32'(6'(rob + 5'd7)));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, w, p0, a0;
    bus.flush_i = 1'b0;
    bus.wb_ready_i = 1'b1;
    drive(3'd0, 7'd0, 1'b0, '0, '0, '0, '0, '0);
    bus.issue_valid_i = 1'b0;
    #12;
    check_reset_vals("reset");
    cyc;
    rst_n = 1'b1;
    cyc;

    one("sll",  3'b001, 7'b0000000, 1'b0, 32'h0000_0001, 32'h0000_001F, 5'd0, 5'd1, 32'h8000_0000, 1'b0);
    one("srai", 3'b101, 7'b0100000, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 5'd2, 32'hF800_0000, 1'b0);
    one("rori", 3'b101, 7'b0110000, 1'b1, 32'h1234_5678, 32'h0,         5'd8, 5'd3, 32'h7812_3456, 1'b0);
    one("bset", 3'b001, 7'b0010100, 1'b0, 32'h0000_0000, 32'd5,         5'd0, 5'd4, 32'h0000_0020, 1'b0);
    one("bext", 3'b101, 7'b0100100, 1'b0, 32'h0000_0020, 32'd5,         5'd0, 5'd5, 32'h0000_0001, 1'b0);
    one("bclr", 3'b001, 7'b0100100, 1'b0, 32'hFFFF_FFFF, 32'd0,         5'd0, 5'd6, 32'hFFFF_FFFE, 1'b0);
    one("binv", 3'b001, 7'b0110100, 1'b0, 32'h0000_0000, 32'd31,        5'd0, 5'd7, 32'h8000_0000, 1'b0);
    one("rol",  3'b001, 7'b0110000, 1'b0, 32'h8000_0001, 32'd4,         5'd0, 5'd8, 32'h0000_0018, 1'b0);
    one("srl",  3'b101, 7'b0000000, 1'b0, 32'h8000_0000, 32'hFFFF_FFE4, 5'd0, 5'd9, 32'h0800_0000, 1'b0);
    one("roli", 3'b001, 7'b0110000, 1'b1, 32'h1234_5678, 32'd0,         5'd3, 5'd10, 32'h0, 1'b1);
    one("ill7", 3'b001, 7'b0000001, 1'b0, 32'h1234_5678, 32'd3,         5'd0, 5'd11, 32'h0, 1'b1);

    // Back-to-back without bubbles at full throughput.
    for (int i = 0; i < 6; i++) begin
      drive(3'b001, 7'b0000000, 1'b0, 32'(i + 1), 32'(i), 5'd0, 5'(12 + i), 6'(i));
      cyc;
    end
    bus.issue_valid_i = 1'b0;
    cyc; cyc;

    // Backpressure: only two ops fit while writeback stalls.
    bus.wb_ready_i = 1'b0;
    a0 = acc_cnt;
    p0 = pop_cnt;
    for (int i = 0; i < 2; i++) begin
      drive(3'b001, 7'b0000000, 1'b0, 32'(3 + i), 32'(i + 1), 5'd0, 5'(20 + i), 6'(40 + i));
      cyc;
    end
    drive(3'b001, 7'b0000000, 1'b0, 32'h5, 32'd3, 5'd0, 5'd22, 6'd42);
    cyc; cyc;
    #1;
    chk("bp ready low", 32'(bus.issue_ready_o), 32'd0);
    chk("bp accepts", 32'(acc_cnt - a0), 32'd2);
    chk("bp held data", bus.wb_data_o, 32'h0000_0006);
    bus.wb_ready_i = 1'b1;
    for (int i = 2; i < 4; i++) begin
      drive(3'b001, 7'b0000000, 1'b0, 32'(3 + i), 32'(i + 1), 5'd0, 5'(20 + i), 6'(40 + i));
      prev = acc_cnt;
      w = 0;
      do begin cyc; w++; end while (acc_cnt == prev && w < 5);
      if (acc_cnt == prev) chk("bp accept timeout", 32'd0, 32'd1);
    end
    bus.issue_valid_i = 1'b0;
    w = 0;
    while (pop_cnt - p0 < 4 && w < 10) begin cyc; w++; end
    chk("bp drained", 32'(pop_cnt - p0), 32'd4);
    cyc; cyc;
    chk("bp no extra", 32'(pop_cnt - p0), 32'd4);

    // Flush with both stages full and a new issue in the same cycle.
    bus.wb_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(3'b101, 7'b0100000, 1'b0, 32'hF000_0000, 32'(i + 2), 5'd0, 5'(24 + i), 6'(50 + i));
      cyc;
    end
    bus.wb_ready_i = 1'b1;
    bus.flush_i = 1'b1;
    drive(3'b001, 7'b0010100, 1'b0, 32'h0, 32'd9, 5'd0, 5'd26, 6'd52);
    #1;
    chk("flush ready", 32'(bus.issue_ready_o), 32'd1);
    cyc;
    bus.flush_i = 1'b0;
    bus.issue_valid_i = 1'b0;
    #1;
    chk("flush valid", 32'(bus.wb_valid_o), 32'd0);
    p0 = pop_cnt;
    cyc; cyc; cyc;
    chk("flush no stale", 32'(pop_cnt - p0), 32'd0);

    // Asynchronous reset mid-stream.
    bus.wb_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(3'b001, 7'b0000000, 1'b0, 32'h1, 32'(i + 1), 5'd0, 5'(27 + i), 6'(60 + i));
      cyc;
    end
    bus.issue_valid_i = 1'b0;
    #1;
    chk("pre-reset valid", 32'(bus.wb_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async reset");
    #1;
    rst_n = 1'b1;
    bus.wb_ready_i = 1'b1;
    cyc;
    one("post-reset sll", 3'b001, 7'b0000000, 1'b0, 32'h0000_0003, 32'd2, 5'd0, 5'd30, 32'h0000_000C, 1'b0);
    cyc; cyc;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
